sprite_pixel_fetch: RTL and testbench

//  Pixel source for color_mapper: per-pixel sprite colour for one 16x16 sprite (Pacman, ghost).

---
 rtl/sprite_pkg.sv | 53 +++++
 rtl/sprite_pixel_fetch_anim_fsm.sv | 85 ++++++++
 rtl/sprite_pixel_fetch.sv | 193 +++++++++++++++++++
 tb/tb_sprite_pixel_fetch.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// -----------------------------------------------------------------------------
// sprite_pkg
//   Shared types and constants for the sprite pixel fetch path.
//   Contents:
//     dir_t         facing direction, encoded exactly as the ROM dir field
//     anim_state_t  animation FSM states
//     PALETTE       16-entry 12-bit RGB palette; index 0 is transparent black
//     SCREEN_W/H    visible raster size
//     palette_rgb() palette lookup helper
// -----------------------------------------------------------------------------
package sprite_pkg;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_UP    = 2'd2,
    DIR_DOWN  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    OPENING = 2'd1,
    CLOSING = 2'd2
  } anim_state_t;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  // {R,G,B} nibbles. Entry 0 is never displayed (transparent).
  localparam logic [11:0] PALETTE [16] = '{
    12'h000,  // 0  transparent
    12'hF00,  // 1  red ghost
    12'hFBF,  // 2  pink ghost
    12'h0FF,  // 3  cyan ghost
    12'hFB5,  // 4  orange ghost
    12'hFF0,  // 5  pacman yellow
    12'h22F,  // 6  frightened blue
    12'hFFF,  // 7  eye white
    12'h00F,  // 8  pupil blue
    12'hF80,  // 9  dark orange
    12'h0F0,  // 10 green
    12'h888,  // 11 grey
    12'hFCC,  // 12 light pink
    12'h808,  // 13 purple
    12'h0A0,  // 14 dark green
    12'h444   // 15 dark grey
  };

  function automatic logic [11:0] palette_rgb(input logic [3:0] idx);
    return PALETTE[idx];
  endfunction

endpackage

// File: rtl/sprite_pixel_fetch_anim_fsm.sv
// -----------------------------------------------------------------------------
// sprite_anim_fsm
//   Animation-frame sequencer for one sprite. Counts frame_start pulses and
//   every ANIM_DIV-th pulse takes one animation step:
//     HOLD    -> OPENING when moving (frame unchanged), otherwise stays put
//     OPENING -> frame+1, turning to CLOSING on reaching FRAMES-1
//     CLOSING -> frame-1, turning to OPENING on reaching 0
//     OPENING/CLOSING with moving=0 -> HOLD, frame unchanged
//   Ports:
//     Clk         in   pixel clock
//     Reset       in   async active-high; state HOLD, frame 0, divider 0
//     frame_start in   one-cycle pulse at start of vblank
//     moving      in   1 = animate, 0 = hold current frame
//     frame       out  current animation frame index (registered)
// -----------------------------------------------------------------------------
module sprite_anim_fsm
  import sprite_pkg::*;
#(
  parameter  int FRAMES   = 4,
  parameter  int ANIM_DIV = 6,
  localparam int FW       = $clog2(FRAMES),
  localparam int DW       = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          frame_start,
  input  logic          moving,
  output logic [FW-1:0] frame
);

  localparam logic [FW-1:0] LAST_FRAME = FW'(FRAMES - 1);
  localparam logic [DW-1:0] DIV_LAST   = DW'(ANIM_DIV - 1);

  anim_state_t   r_state;
  logic [FW-1:0] r_frame;
  logic [DW-1:0] r_div;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= HOLD;
      r_frame <= '0;
      r_div   <= '0;
    end else if (frame_start) begin
      if (r_div == DIV_LAST) begin
        r_div <= '0;
        case (r_state)
          HOLD: begin
            if (moving) r_state <= OPENING;
          end
          OPENING: begin
            if (!moving) begin
              r_state <= HOLD;
            end else if (r_frame == LAST_FRAME) begin
              // Only reachable when resuming from HOLD at the last frame:
              // turn around instead of wrapping.
              r_frame <= r_frame - 1'b1;
              r_state <= CLOSING;
            end else begin
              r_frame <= r_frame + 1'b1;
              if (r_frame == LAST_FRAME - 1'b1) r_state <= CLOSING;
            end
          end
          CLOSING: begin
            if (!moving) begin
              r_state <= HOLD;
            end else if (r_frame == '0) begin
              // Resuming from HOLD at frame 0: turn around instead of wrapping.
              r_frame <= r_frame + 1'b1;
              r_state <= OPENING;
            end else begin
              r_frame <= r_frame - 1'b1;
              if (r_frame == FW'(1)) r_state <= OPENING;
            end
          end
          default: r_state <= HOLD;
        endcase
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

  assign frame = r_frame;

endmodule

// File: rtl/sprite_pixel_fetch.sv
// -----------------------------------------------------------------------------
// sprite_pixel_fetch
//   Per-pixel colour source for one 16x16 sprite. For each valid DrawX/DrawY
//   it decides whether the pixel lies in the sprite box, addresses the
//   palette-index ROM as {dir, frame, row, col}, and palettises the returned
//   index. Output is RGB plus a hit flag, aligned with delayed DrawX/DrawY.
//   Latency from pix_valid to out_valid is ROM_LAT+2 cycles, one pixel per
//   clock, no stalls.
//
//   Build option: define SPRITE_MIRROR_EN to draw "left" as a horizontally
//   mirrored copy of the "right" art (ROM dir-1 slot then unused). Latency is
//   the same either way.
//
//   Ports:
//     Clk, Reset          pixel clock, async active-high reset
//     frame_start         vblank pulse, drives the animation FSM
//     pix_valid           DrawX/DrawY valid this cycle
//     DrawX, DrawY        current raster position (10 bit)
//     SpriteX, SpriteY    sprite centre (10 bit)
//     dir                 facing 0 right, 1 left, 2 up, 3 down
//     moving              animate when 1, hold frame when 0
//     rom_addr  (out, AW) {dir, frame, row, col} to the sprite ROM
//     rom_data  (in, 4)   palette index, ROM_LAT cycles after rom_addr
//     out_valid           outputs valid
//     out_x, out_y        DrawX/DrawY aligned with RGB
//     spr_red/green/blue  sprite colour, 0 when no hit
//     spr_hit             in box and palette index != 0
// -----------------------------------------------------------------------------
module sprite_pixel_fetch
  import sprite_pkg::*;
#(
  parameter  int SPRITE_S = 16,
  parameter  int FRAMES   = 4,
  parameter  int ROM_LAT  = 2,
  parameter  int ANIM_DIV = 6,
  localparam int SW       = $clog2(SPRITE_S),
  localparam int FW       = $clog2(FRAMES),
  localparam int AW       = 2 + FW + 2 * SW
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          frame_start,
  input  logic          pix_valid,
  input  logic [9:0]    DrawX,
  input  logic [9:0]    DrawY,
  input  logic [9:0]    SpriteX,
  input  logic [9:0]    SpriteY,
  input  logic [1:0]    dir,
  input  logic          moving,
  output logic [AW-1:0] rom_addr,
  input  logic [3:0]    rom_data,
  output logic          out_valid,
  output logic [9:0]    out_x,
  output logic [9:0]    out_y,
  output logic [3:0]    spr_red,
  output logic [3:0]    spr_green,
  output logic [3:0]    spr_blue,
  output logic          spr_hit
);

  localparam logic signed [10:0] HALF_S = 11'(SPRITE_S / 2);
  localparam logic signed [10:0] SIDE_S = 11'(SPRITE_S);

  // ---------------------------------------------------------------------------
  // Animation frame
  // ---------------------------------------------------------------------------
  logic [FW-1:0] w_frame;

  sprite_anim_fsm #(
    .FRAMES   (FRAMES),
    .ANIM_DIV (ANIM_DIV)
  ) u_anim (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_start (frame_start),
    .moving      (moving),
    .frame       (w_frame)
  );

  // ---------------------------------------------------------------------------
  // Region test: signed offsets so sprites hanging off the left/top edge clip
  // instead of wrapping to the far side of the screen.
  // ---------------------------------------------------------------------------
  logic signed [10:0] w_dx;
  logic signed [10:0] w_dy;
  logic               w_in_box;
  logic [SW-1:0]      w_col;
  logic [SW-1:0]      w_row;

  assign w_dx     = $signed({1'b0, DrawX}) - $signed({1'b0, SpriteX}) + HALF_S;
  assign w_dy     = $signed({1'b0, DrawY}) - $signed({1'b0, SpriteY}) + HALF_S;
  assign w_in_box = (w_dx >= 11'sd0) && (w_dx < SIDE_S) &&
                    (w_dy >= 11'sd0) && (w_dy < SIDE_S);
  assign w_col    = w_dx[SW-1:0];
  assign w_row    = w_dy[SW-1:0];

  logic [1:0]    w_dir_eff;
  logic [SW-1:0] w_col_eff;

`ifdef SPRITE_MIRROR_EN
  // Left-facing reuses the right-facing art; ~col == SPRITE_S-1-col since
  // SPRITE_S is a power of two.
  always_comb begin
    w_dir_eff = dir;
    w_col_eff = w_col;
    if (dir == DIR_LEFT) begin
      w_dir_eff = DIR_RIGHT;
      w_col_eff = ~w_col;
    end
  end
`else
  assign w_dir_eff = dir;
  assign w_col_eff = w_col;
`endif

  // ---------------------------------------------------------------------------
  // S0: ROM address and region flag. Out-of-box pixels leave the address
  // untouched so the ROM sees no spurious activity.
  // Stage index 0 of the sideband shift is S0; index ROM_LAT lines up with
  // rom_data.
  // ---------------------------------------------------------------------------
  logic [AW-1:0]    r_rom_addr;
  logic [ROM_LAT:0] r_vld_p;
  logic [ROM_LAT:0] r_in_p;
  logic [9:0]       r_x_p [0:ROM_LAT];
  logic [9:0]       r_y_p [0:ROM_LAT];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_rom_addr <= '0;
      r_vld_p    <= '0;
      r_in_p     <= '0;
    end else begin
      if (pix_valid && w_in_box) r_rom_addr <= {w_dir_eff, w_frame, w_row, w_col_eff};
      if (ROM_LAT > 0) begin
        r_vld_p <= {r_vld_p[ROM_LAT-1:0], pix_valid};
        r_in_p  <= {r_in_p[ROM_LAT-1:0], pix_valid & w_in_box};
      end
    end
  end

  // Coordinate sideband carries no control meaning, so it is not reset.
  always_ff @(posedge Clk) begin
    r_x_p[0] <= DrawX;
    r_y_p[0] <= DrawY;
    for (int i = 1; i <= ROM_LAT; i++) begin
      r_x_p[i] <= r_x_p[i-1];
      r_y_p[i] <= r_y_p[i-1];
    end
  end

  assign rom_addr = r_rom_addr;

  // ---------------------------------------------------------------------------
  // Final stage: palettise. Index 0 is transparent.
  // ---------------------------------------------------------------------------
  logic        w_hit;
  logic [11:0] w_rgb;

  assign w_hit = r_vld_p[ROM_LAT] & r_in_p[ROM_LAT] & (rom_data != 4'd0);
  assign w_rgb = w_hit ? palette_rgb(rom_data) : 12'h000;

  logic        r_out_valid;
  logic        r_hit;
  logic [11:0] r_rgb;
  logic [9:0]  r_out_x;
  logic [9:0]  r_out_y;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_out_valid <= 1'b0;
      r_hit       <= 1'b0;
      r_rgb       <= 12'h000;
      r_out_x     <= '0;
      r_out_y     <= '0;
    end else begin
      r_out_valid <= r_vld_p[ROM_LAT];
      r_hit       <= w_hit;
      r_rgb       <= w_rgb;
      r_out_x     <= r_x_p[ROM_LAT];
      r_out_y     <= r_y_p[ROM_LAT];
    end
  end

  assign out_valid = r_out_valid;
  assign spr_hit   = r_hit;
  assign spr_red   = r_rgb[11:8];
  assign spr_green = r_rgb[7:4];
  assign spr_blue  = r_rgb[3:0];
  assign out_x     = r_out_x;
  assign out_y     = r_out_y;

endmodule

// File: tb/tb_sprite_pixel_fetch.sv
module tb_sprite_pixel_fetch;

  localparam int LAT = 4;  // ROM_LAT(2) + 2

  localparam logic [11:0] EXP_PAL [16] = '{
    12'h000, 12'hF00, 12'hFBF, 12'h0FF, 12'hFB5, 12'hFF0, 12'h22F, 12'hFFF,
    12'h00F, 12'hF80, 12'h0F0, 12'h888, 12'hFCC, 12'h808, 12'h0A0, 12'h444
  };

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_start;
  logic        pix_valid;
  logic [9:0]  DrawX, DrawY, SpriteX, SpriteY;
  logic [1:0]  dir;
  logic        moving;
  logic [11:0] rom_addr;
  logic [3:0]  rom_data;
  logic        out_valid;
  logic [9:0]  out_x, out_y;
  logic [3:0]  spr_red, spr_green, spr_blue;
  logic        spr_hit;

  int checks   = 0;
  int failures = 0;

  sprite_pixel_fetch dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_start (frame_start),
    .pix_valid   (pix_valid),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .SpriteX     (SpriteX),
    .SpriteY     (SpriteY),
    .dir         (dir),
    .moving      (moving),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .out_valid   (out_valid),
    .out_x       (out_x),
    .out_y       (out_y),
    .spr_red     (spr_red),
    .spr_green   (spr_green),
    .spr_blue    (spr_blue),
    .spr_hit     (spr_hit)
  );

  always #5 Clk = ~Clk;

  // Two-cycle ROM: mode 0 returns a constant index, mode 1 returns the column.
  logic [11:0] rom_a1;
  int          rom_mode;
  logic [3:0]  rom_const;
  always @(posedge Clk) begin
    rom_a1   <= rom_addr;
    rom_data <= (rom_mode == 1) ? rom_a1[3:0] : rom_const;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // One isolated pixel; returns when its result is on the outputs.
  task automatic drive_pixel(input logic [9:0] x, input logic [9:0] y);
    DrawX     = x;
    DrawY     = y;
    pix_valid = 1'b1;
    tick();
    pix_valid = 1'b0;
    repeat (LAT - 1) tick();
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    int cnt;
    Reset = 1'b1;
    repeat (3) tick();
    checks++;
    if ({out_valid, spr_hit, spr_red, spr_green, spr_blue} !== 14'd0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%0b hit=%0b rgb=%h, want all 0", out_valid, spr_hit,
               {spr_red, spr_green, spr_blue});
    end
    checks++;
    if (rom_addr !== 12'd0) begin
      failures++;
      $display("FAIL reset_rom_addr: got %h want 000", rom_addr);
    end
    Reset = 1'b0;
    tick();
    // Stream in-box pixels, then hit reset mid-cycle.
    SpriteX = 10'd100; SpriteY = 10'd50; rom_mode = 0; rom_const = 4'd5; dir = 2'd0;
    for (int i = 0; i < 6; i++) begin
      DrawX = 10'(92 + i); DrawY = 10'd50; pix_valid = 1'b1;
      tick();
    end
    checks++;
    if ({out_valid, spr_hit} !== 2'b11) begin
      failures++;
      $display("FAIL stream_before_reset: got v=%0b hit=%0b want 1 1", out_valid, spr_hit);
    end
    #2;
    Reset = 1'b1;
    #1;
    checks++;
    if ({out_valid, spr_hit, spr_red, spr_green, spr_blue} !== 14'd0) begin
      failures++;
      $display("FAIL async_reset: got v=%0b hit=%0b rgb=%h, want all 0", out_valid, spr_hit,
               {spr_red, spr_green, spr_blue});
    end
    pix_valid = 1'b0;
    tick();
    Reset = 1'b0;
    repeat (LAT + 1) tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL inflight_discarded: got out_valid=%0b want 0", out_valid);
    end
    DrawX = 10'd95; DrawY = 10'd50; pix_valid = 1'b1;
    cnt = 0;
    do begin
      tick();
      pix_valid = 1'b0;
      cnt++;
    end while (out_valid !== 1'b1 && cnt < 20);
    checks++;
    if (cnt != LAT) begin
      failures++;
      $display("FAIL first_latency: got %0d cycles want %0d", cnt, LAT);
    end
  endtask

  task automatic test_region();
    logic [9:0]  xs [5] = '{10'd91, 10'd92, 10'd99, 10'd107, 10'd108};
    logic        xh [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [9:0]  ys [4] = '{10'd41, 10'd42, 10'd57, 10'd58};
    logic        yh [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [11:0] want;
    SpriteX = 10'd100; SpriteY = 10'd50; rom_mode = 0; rom_const = 4'd5; dir = 2'd0;
    for (int i = 0; i < 5; i++) begin
      drive_pixel(xs[i], 10'd50);
      want = xh[i] ? 12'hFF0 : 12'h000;
      checks++;
      if ({out_valid, spr_hit, spr_red, spr_green, spr_blue} !== {1'b1, xh[i], want}) begin
        failures++;
        $display("FAIL region_x%0d: got v=%0b hit=%0b rgb=%h want v=1 hit=%0b rgb=%h", xs[i],
                 out_valid, spr_hit, {spr_red, spr_green, spr_blue}, xh[i], want);
      end
    end
    for (int i = 0; i < 4; i++) begin
      drive_pixel(10'd100, ys[i]);
      want = yh[i] ? 12'hFF0 : 12'h000;
      checks++;
      if ({out_valid, spr_hit, spr_red, spr_green, spr_blue} !== {1'b1, yh[i], want}) begin
        failures++;
        $display("FAIL region_y%0d: got v=%0b hit=%0b rgb=%h want v=1 hit=%0b rgb=%h", ys[i],
                 out_valid, spr_hit, {spr_red, spr_green, spr_blue}, yh[i], want);
      end
    end
    rom_const = 4'd0;
    drive_pixel(10'd100, 10'd50);
    checks++;
    if ({out_valid, spr_hit, spr_red, spr_green, spr_blue} !== {1'b1, 1'b0, 12'h000}) begin
      failures++;
      $display("FAIL transparent: got v=%0b hit=%0b rgb=%h want v=1 hit=0 rgb=000", out_valid,
               spr_hit, {spr_red, spr_green, spr_blue});
    end
  endtask

  task automatic test_edge_clip();
    SpriteX = 10'd3; SpriteY = 10'd3; rom_mode = 0; rom_const = 4'd5; dir = 2'd0;
    DrawX = 10'd0; DrawY = 10'd0; pix_valid = 1'b1;
    tick();
    pix_valid = 1'b0;
    checks++;
    if ({rom_addr[7:4], rom_addr[3:0]} !== 8'h55) begin
      failures++;
      $display("FAIL clip_addr: got row=%0d col=%0d want row=5 col=5", rom_addr[7:4], rom_addr[3:0]);
    end
    repeat (LAT - 1) tick();
    checks++;
    if ({out_valid, spr_hit} !== 2'b11) begin
      failures++;
      $display("FAIL clip_hit: got v=%0b hit=%0b want 1 1", out_valid, spr_hit);
    end
    drive_pixel(10'd639, 10'd0);
    checks++;
    if ({out_valid, spr_hit, spr_red, spr_green, spr_blue} !== {1'b1, 1'b0, 12'h000}) begin
      failures++;
      $display("FAIL no_wrap: got v=%0b hit=%0b rgb=%h want v=1 hit=0 rgb=000", out_valid, spr_hit,
               {spr_red, spr_green, spr_blue});
    end
    checks++;
    if (rom_addr[7:0] !== 8'h55) begin
      failures++;
      $display("FAIL addr_hold: got %h want low byte 55", rom_addr);
    end
  endtask

  task automatic test_mirror();
    logic [1:0] want_dir;
    logic [3:0] want_col;
`ifdef SPRITE_MIRROR_EN
    want_dir = 2'd0; want_col = 4'd15;
`else
    want_dir = 2'd1; want_col = 4'd0;
`endif
    SpriteX = 10'd100; SpriteY = 10'd50; dir = 2'd1;
    DrawX = 10'd92; DrawY = 10'd50; pix_valid = 1'b1;
    tick();
    pix_valid = 1'b0;
    dir = 2'd0;
    checks++;
    if (rom_addr !== {want_dir, 2'd0, 4'd8, want_col}) begin
      failures++;
      $display("FAIL mirror_addr: got %h want %h", rom_addr, {want_dir, 2'd0, 4'd8, want_col});
    end
    repeat (LAT) tick();
  endtask

  // Sample the animation frame through the rom_addr frame field.
  task automatic sample_frame(output logic [1:0] f);
    DrawX = SpriteX; DrawY = SpriteY; pix_valid = 1'b1;
    tick();
    pix_valid = 1'b0;
    f = rom_addr[9:8];
  endtask

  task automatic test_anim();
    logic [1:0] exp_seq [10] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0, 2'd1, 2'd2, 2'd3};
    logic [1:0] f;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    SpriteX = 10'd200; SpriteY = 10'd200; dir = 2'd0; moving = 1'b1;
    for (int p = 1; p <= 60; p++) begin
      pulse_frame();
      if (p == 5 || p % 6 == 0) begin
        sample_frame(f);
        checks++;
        if (f !== ((p == 5) ? 2'd0 : exp_seq[p/6 - 1])) begin
          failures++;
          $display("FAIL anim_pulse%0d: got frame %0d want %0d", p, f,
                   (p == 5) ? 2'd0 : exp_seq[p/6 - 1]);
        end
      end
    end
    repeat (6) pulse_frame();
    sample_frame(f);
    checks++;
    if (f !== 2'd2) begin
      failures++;
      $display("FAIL anim_close: got frame %0d want 2", f);
    end
    moving = 1'b0;
    for (int s = 0; s < 2; s++) begin
      repeat (6) pulse_frame();
      sample_frame(f);
      checks++;
      if (f !== 2'd2) begin
        failures++;
        $display("FAIL anim_hold%0d: got frame %0d want 2", s, f);
      end
    end
    repeat (LAT) tick();
  endtask

  task automatic test_back_to_back();
    int          n_out;
    int          exp_x;
    int          dx;
    logic        want_hit;
    logic [11:0] want_rgb;
    SpriteX = 10'd320; SpriteY = 10'd100; dir = 2'd0; rom_mode = 1;
    repeat (LAT) tick();
    n_out = 0;
    exp_x = 0;
    for (int c = 0; c < 650; c++) begin
      if (c < 640) begin
        pix_valid = 1'b1; DrawX = 10'(c); DrawY = 10'd100;
      end else begin
        pix_valid = 1'b0;
      end
      tick();
      if (out_valid === 1'b1) begin
        dx       = exp_x - 312;
        want_hit = (dx >= 1) && (dx <= 15);
        want_rgb = want_hit ? EXP_PAL[dx[3:0]] : 12'h000;
        checks++;
        if ({out_x, out_y, spr_hit, spr_red, spr_green, spr_blue} !==
            {10'(exp_x), 10'd100, want_hit, want_rgb}) begin
          failures++;
          $display("FAIL tput_px: got x=%0d y=%0d hit=%0b rgb=%h want x=%0d y=100 hit=%0b rgb=%h",
                   out_x, out_y, spr_hit, {spr_red, spr_green, spr_blue}, exp_x, want_hit, want_rgb);
        end
        exp_x++;
        n_out++;
      end
    end
    checks++;
    if (n_out != 640) begin
      failures++;
      $display("FAIL tput_count: got %0d valid cycles want 640", n_out);
    end
  endtask

  initial begin
    Reset = 1'b1; frame_start = 1'b0; pix_valid = 1'b0; moving = 1'b0;
    DrawX = '0; DrawY = '0; SpriteX = '0; SpriteY = '0; dir = 2'd0;
    rom_mode = 0; rom_const = 4'd0;
    test_reset();
    test_region();
    test_edge_clip();
    test_mirror();
    test_anim();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
